// File: rtl/pix_pair_packer_if.sv
// Write-side bus of the pixel pair packer: one 36-bit word plus its ZBT address,
// transferred on a valid/ready handshake.
interface pix_pair_packer_if #(
  parameter int ADDR_W = 19
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [35:0]       wr_data;
  logic              wr_ready;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/pix_pair_packer.sv
// Packs consecutive even/odd RGB666 pixels into 36-bit ZBT words and buffers them
// in a small first-word-fall-through FIFO with sticky overflow/pairing error flags.
module pix_pair_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 19
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_valid,
  input  logic [23:0]                   pix_rgb,
  input  logic [10:0]                   hcount,
  input  logic [9:0]                    vcount,
  input  logic                          clr_flags,
  pix_pair_packer_if.master             wr_bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          pair_err
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int PIX_AW = 19;

  typedef enum logic {EMPTY, HALF} pair_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [35:0]       data;
  } word_t;

  // Pixel decode
  logic [17:0]       pix666;
  logic [PIX_AW-1:0] pix_addr;
  logic              pix_odd;
  logic              unused_pix_bits;

  assign pix666   = {pix_rgb[23:18], pix_rgb[15:10], pix_rgb[7:2]};
  assign pix_addr = {vcount[8:0], hcount[10:1]};
  assign pix_odd  = hcount[0];
  assign unused_pix_bits = ^{vcount[9], pix_rgb[17:16], pix_rgb[9:8], pix_rgb[1:0]};

  // Pairing FSM
  pair_state_e       state, next_state;
  logic [17:0]       hold_pix;
  logic [PIX_AW-1:0] hold_addr;
  logic              hold_load;
  logic              push;
  logic              pair_bad;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    if (pix_valid) begin
      case (state)
        EMPTY:   next_state = pix_odd ? EMPTY : HALF;
        HALF:    next_state = pix_odd ? EMPTY : HALF;
        default: next_state = EMPTY;
      endcase
    end
  end

  always_comb begin
    hold_load = 1'b0;
    push      = 1'b0;
    pair_bad  = 1'b0;
    if (pix_valid) begin
      case (state)
        EMPTY: begin
          if (pix_odd) pair_bad  = 1'b1;
          else         hold_load = 1'b1;
        end
        HALF: begin
          if (!pix_odd) begin
            // A second even pixel replaces the held one.
            pair_bad  = 1'b1;
            hold_load = 1'b1;
          end else if (pix_addr == hold_addr) begin
            push = 1'b1;
          end else begin
            pair_bad = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_pix  <= '0;
      hold_addr <= '0;
    end else if (hold_load) begin
      hold_pix  <= pix666;
      hold_addr <= pix_addr;
    end
  end

  // FWFT FIFO
  word_t             mem [FIFO_DEPTH];
  word_t             push_word;
  word_t             head_word;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              head_valid;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;
  logic              ovf_evt;

  assign push_word.addr = ADDR_W'(hold_addr);
  assign push_word.data = {pix666, hold_pix};

  assign head_valid = (level != '0);
  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign pop        = head_valid && wr_bus.wr_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push_ok    = push && (!fifo_full || pop);
  assign ovf_evt    = push && fifo_full && !pop;

  // NOTE: the storage array has no reset; only pointers and level are reset,
  // and the outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    head_word = '0;
    if (head_valid) head_word = mem[rd_ptr];
  end

  assign wr_bus.wr_valid = head_valid;
  assign wr_bus.wr_addr  = head_word.addr;
  assign wr_bus.wr_data  = head_word.data;
  assign fifo_level      = level;

  // Sticky flags: a new error in the clearing cycle wins over clr_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      pair_err <= 1'b0;
    end else begin
      if (ovf_evt)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;

      if (pair_bad)       pair_err <= 1'b1;
      else if (clr_flags) pair_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pix_pair_packer.sv
// Directed bench for pix_pair_packer: table of single-cycle vectors followed by
// hand-written backpressure, full-with-pop and mid-frame reset sequences.
module tb_pix_pair_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_rgb = '0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        clr_flags = 1'b0;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        pair_err;

  int n_checks = 0;
  int n_errors = 0;

  pix_pair_packer_if #(.ADDR_W(19)) wr_bus ();

  pix_pair_packer #(.FIFO_DEPTH(4), .ADDR_W(19)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_rgb    (pix_rgb),
    .hcount     (hcount),
    .vcount     (vcount),
    .clr_flags  (clr_flags),
    .wr_bus     (wr_bus.master),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .pair_err   (pair_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        pv;
    logic [10:0] h;
    logic [9:0]  v;
    logic [23:0] rgb;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [18:0] e_addr;
    logic [35:0] e_data;
    logic [2:0]  e_lvl;
    logic        e_ovf;
    logic        e_perr;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic drive(input logic rst, input logic pv, input logic [10:0] h,
                       input logic [9:0] v, input logic [23:0] rgb,
                       input logic rdy, input logic clr);
    @(negedge clk);
    reset           = rst;
    pix_valid       = pv;
    hcount          = h;
    vcount          = v;
    pix_rgb         = rgb;
    wr_bus.wr_ready = rdy;
    clr_flags       = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 11'd0, 10'd0, 24'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 11'd0, 10'd0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy, input logic clr);
    drive(1'b0, 1'b0, 11'd0, 10'd0, 24'h0, rdy, clr);
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [18:0] ea,
                               input logic [35:0] ed, input logic [2:0] el,
                               input logic eo, input logic ep);
    check({tag, ".wr_valid"},   64'(wr_bus.wr_valid), 64'(ev));
    check({tag, ".wr_addr"},    64'(wr_bus.wr_addr),  64'(ea));
    check({tag, ".wr_data"},    64'(wr_bus.wr_data),  64'(ed));
    check({tag, ".fifo_level"}, 64'(fifo_level),      64'(el));
    check({tag, ".overflow"},   64'(overflow),        64'(eo));
    check({tag, ".pair_err"},   64'(pair_err),        64'(ep));
  endtask

  function automatic logic [17:0] to666(input logic [23:0] rgb);
    return {rgb[23:18], rgb[15:10], rgb[7:2]};
  endfunction

  function automatic logic [35:0] word_of(input logic [23:0] even_rgb, input logic [23:0] odd_rgb);
    return {to666(odd_rgb), to666(even_rgb)};
  endfunction

  logic [23:0] even_c [5];
  logic [23:0] odd_c  [5];
  vec_t        vecs   [17];

  initial begin
    even_c = '{24'hFFFFFF, 24'h0C1824, 24'h808080, 24'h3C7FC0, 24'hA55AF0};
    odd_c  = '{24'h000000, 24'hF0E0D0, 24'h040404, 24'h123456, 24'h9ABCDE};

    //          pv  h      v      rgb         rdy clr  valid addr      data                                             lvl ovf perr
    vecs[0]  = '{1, 11'd4,  10'd3, 24'hFF8040, 1, 0,   0, 19'h0,     36'h0,                                             0,  0,  0};
    vecs[1]  = '{0, 11'd5,  10'd3, 24'h102030, 1, 0,   0, 19'h0,     36'h0,                                             0,  0,  0};
    vecs[2]  = '{1, 11'd5,  10'd3, 24'h102030, 1, 0,   1, 19'h00C02, {6'h04,6'h08,6'h0C,6'h3F,6'h20,6'h10},             1,  0,  0};
    vecs[3]  = '{0, 11'd0,  10'd0, 24'h000000, 1, 0,   0, 19'h0,     36'h0,                                             0,  0,  0};
    vecs[4]  = '{1, 11'd7,  10'd3, 24'h123456, 1, 0,   0, 19'h0,     36'h0,                                             0,  0,  1};
    vecs[5]  = '{0, 11'd0,  10'd0, 24'h000000, 1, 1,   0, 19'h0,     36'h0,                                             0,  0,  0};
    vecs[6]  = '{1, 11'd8,  10'd3, 24'hFCFCFC, 1, 0,   0, 19'h0,     36'h0,                                             0,  0,  0};
    vecs[7]  = '{1, 11'd10, 10'd3, 24'h040810, 1, 0,   0, 19'h0,     36'h0,                                             0,  0,  1};
    vecs[8]  = '{1, 11'd11, 10'd3, 24'h808080, 0, 0,   1, 19'h00C05, {6'h20,6'h20,6'h20,6'h01,6'h02,6'h04},             1,  0,  1};
    vecs[9]  = '{0, 11'd0,  10'd0, 24'h000000, 0, 0,   1, 19'h00C05, {6'h20,6'h20,6'h20,6'h01,6'h02,6'h04},             1,  0,  1};
    vecs[10] = '{0, 11'd0,  10'd0, 24'h000000, 1, 0,   0, 19'h0,     36'h0,                                             0,  0,  1};
    vecs[11] = '{1, 11'd20, 10'd4, 24'h111111, 1, 1,   0, 19'h0,     36'h0,                                             0,  0,  0};
    vecs[12] = '{1, 11'd23, 10'd4, 24'h222222, 1, 0,   0, 19'h0,     36'h0,                                             0,  0,  1};
    vecs[13] = '{1, 11'd21, 10'd4, 24'h333333, 1, 1,   0, 19'h0,     36'h0,                                             0,  0,  1};
    vecs[14] = '{0, 11'd0,  10'd0, 24'h000000, 1, 1,   0, 19'h0,     36'h0,                                             0,  0,  0};
    vecs[15] = '{1, 11'd30, 10'd5, 24'h444444, 1, 0,   0, 19'h0,     36'h0,                                             0,  0,  0};
    vecs[16] = '{1, 11'd31, 10'd6, 24'h555555, 1, 0,   0, 19'h0,     36'h0,                                             0,  0,  1};

    wr_bus.wr_ready = 1'b0;

    // Reset state
    do_reset();
    check_outputs("reset", 0, 19'h0, 36'h0, 3'd0, 0, 0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, vecs[i].pv, vecs[i].h, vecs[i].v, vecs[i].rgb, vecs[i].rdy, vecs[i].clr);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_data,
                    vecs[i].e_lvl, vecs[i].e_ovf, vecs[i].e_perr);
    end

    // Backpressure: five pairs into a four-deep FIFO, then drain
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 11'(2*i),     10'd1, even_c[i], 1'b0, 1'b0);
      drive(1'b0, 1'b1, 11'(2*i + 1), 10'd1, odd_c[i],  1'b0, 1'b0);
      check_outputs($sformatf("bp_push%0d", i), 1, 19'h00400, word_of(even_c[0], odd_c[0]),
                    (i < 4) ? 3'(i + 1) : 3'd4, (i == 4), 0);
    end
    drive(1'b0, 1'b1, 11'd21, 10'd1, 24'h777777, 1'b0, 1'b0);
    check("bp_orphan.overflow", 64'(overflow), 64'd1);
    check("bp_orphan.pair_err", 64'(pair_err), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check_outputs($sformatf("bp_head%0d", k), 1, 19'(19'h00400 + k),
                    word_of(even_c[k], odd_c[k]), 3'(4 - k), 1, 1);
      idle(1'b1, 1'b0);
    end
    check_outputs("bp_drained", 0, 19'h0, 36'h0, 3'd0, 1, 1);
    idle(1'b1, 1'b0);
    check("bp_no_extra.wr_valid", 64'(wr_bus.wr_valid), 64'd0);

    // Flag clear with no new error
    idle(1'b1, 1'b1);
    check("clr.overflow", 64'(overflow), 64'd0);
    check("clr.pair_err", 64'(pair_err), 64'd0);

    // Full FIFO with a pair completing while the head pops
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 11'(2*i),     10'd2, even_c[i], 1'b0, 1'b0);
      drive(1'b0, 1'b1, 11'(2*i + 1), 10'd2, odd_c[i],  1'b0, 1'b0);
    end
    check("full.fifo_level", 64'(fifo_level), 64'd4);
    drive(1'b0, 1'b1, 11'd8, 10'd2, even_c[4], 1'b0, 1'b0);
    drive(1'b0, 1'b1, 11'd9, 10'd2, odd_c[4],  1'b1, 1'b0);
    check_outputs("full_pop", 1, 19'h00801, word_of(even_c[1], odd_c[1]), 3'd4, 0, 0);
    for (int k = 1; k < 5; k++) begin
      check_outputs($sformatf("full_head%0d", k), 1, 19'(19'h00800 + k),
                    word_of(even_c[k], odd_c[k]), 3'(5 - k), 0, 0);
      idle(1'b1, 1'b0);
    end
    check_outputs("full_drained", 0, 19'h0, 36'h0, 3'd0, 0, 0);

    // Reset mid-frame while a half pair and two words are held
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 11'(2*i),     10'd7, even_c[i], 1'b0, 1'b0);
      drive(1'b0, 1'b1, 11'(2*i + 1), 10'd7, odd_c[i],  1'b0, 1'b0);
    end
    drive(1'b0, 1'b1, 11'd4, 10'd7, even_c[2], 1'b0, 1'b0);
    check("mid.fifo_level", 64'(fifo_level), 64'd2);
    drive(1'b1, 1'b1, 11'd5, 10'd7, odd_c[2], 1'b1, 1'b0);
    check_outputs("mid_reset", 0, 19'h0, 36'h0, 3'd0, 0, 0);
    drive(1'b0, 1'b1, 11'd5, 10'd7, odd_c[2], 1'b1, 1'b0);
    check_outputs("mid_after", 0, 19'h0, 36'h0, 3'd0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pix_pair_packer.md
PIX_PAIR_PACKER -- requirements
Module: pix_pair_packer

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of 36-bit words buffered; power of two, minimum 2.
REQ-002 Parameter: ADDR_W, 19, width of the ZBT word address.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pix_valid  input  1  pix_rgb/hcount/vcount are valid this cycle.
REQ-006 pix_rgb  input  24  {R[7:0],G[7:0],B[7:0]} processed pixel.
REQ-007 hcount  input  11  pixel column; bit 0 selects the half-word.
REQ-008 vcount  input  10  pixel line.
REQ-009 wr_ready  input  1  memory side accepts the word this cycle.
REQ-010 clr_flags  input  1  clears the sticky error flags.
REQ-011 wr_valid  output  1  wr_addr/wr_data hold a word to write.
REQ-012 wr_addr  output  ADDR_W  word address = {vcount[8:0], hcount[10:1]}.
REQ-013 wr_data  output  36  packed pixel pair.
REQ-014 fifo_level  output  log2(FIFO_DEPTH)+1  words currently buffered.
REQ-015 overflow  output  1  sticky: a completed word was dropped because the FIFO was full.
REQ-016 pair_err  output  1  sticky: an even pixel was discarded or an odd pixel arrived unpaired.

Function
REQ-017 Each pixel SHALL be truncated to RGB666: {R[7:2],G[7:2],B[7:2]} (18 bits).
REQ-018 The even pixel (hcount[0]=0) SHALL occupy wr_data[17:0] and the odd pixel (hcount[0]=1) SHALL occupy wr_data[35:18].
REQ-019 The pairing FSM SHALL have two states: EMPTY (no even pixel held) and HALF (even pixel, address held).
REQ-020 EMPTY + valid even pixel -> latch pixel and address, go to HALF.
REQ-021 EMPTY + valid odd pixel -> discard the pixel, set pair_err, stay in EMPTY.
REQ-022 HALF + valid odd pixel with matching {vcount[8:0],hcount[10:1]} -> push the word to the FIFO, go to EMPTY.
REQ-023 HALF + valid odd pixel with a non-matching address -> discard both pixels, set pair_err, go to EMPTY.
REQ-024 HALF + valid even pixel -> discard the held pixel, set pair_err, latch the new pixel, stay in HALF.
REQ-025 pix_valid=0 SHALL leave the FSM state and held data unchanged.
REQ-026 FIFO output is first-word-fall-through: wr_valid=1 whenever fifo_level>0; wr_addr/wr_data show the head word.
REQ-027 A transfer occurs on a cycle with wr_valid=1 and wr_ready=1; the head word is popped at that edge.
REQ-028 wr_addr/wr_data SHALL stay stable while wr_valid=1 and wr_ready=0.
REQ-029 Latency: a word completed at edge N into an empty FIFO SHALL show wr_valid=1 in the cycle after edge N.
REQ-030 Push when fifo_level=FIFO_DEPTH and no pop in the same cycle: drop the word, set overflow, level unchanged.
REQ-031 Push and pop in the same cycle: both SHALL take effect (a full FIFO accepts the word); level unchanged.
REQ-032 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 clr_flags=1 SHALL clear overflow and pair_err at the next edge, unless a new error occurs in the same cycle; the new error wins.

Reset
REQ-034 reset=1 SHALL synchronously set the FSM to EMPTY, set fifo_level=0, wr_valid=0, wr_addr=0, wr_data=0, overflow=0 and pair_err=0.
REQ-035 Reset mid-operation SHALL discard the held half-pixel and all buffered words.
REQ-036 reset SHALL take priority over every other input.

Verification
REQ-037 Pair write: hcount=4 rgb=FF8040, then hcount=5 rgb=102030, vcount=3, wr_ready=1 -> one cycle later wr_valid=1, wr_addr=0x00C02, wr_data={6'h04,6'h08,6'h0C,6'h3F,6'h20,6'h10}.
REQ-038 Backpressure: wr_ready=0, 5 pairs pushed with FIFO_DEPTH=4 -> fifo_level=4, overflow=1, head word stable; then wr_ready=1 -> exactly the first 4 words drain, in order.
REQ-039 Orphans: odd hcount=7 alone -> pair_err=1, no word; even 8 then even 10 then odd 11 -> pair_err=1, one word at hcount[10:1]=5 from pixels 10 and 11.
REQ-040 Full with simultaneous pop: level=4, wr_ready=1, pair completes -> level stays 4, overflow stays 0.
REQ-041 Reset mid-frame: FSM in HALF with level=2, assert reset one cycle -> wr_valid=0, level=0, flags 0; next odd pixel -> pair_err=1.
REQ-042 Flag clear: overflow=1, pair_err=1, clr_flags pulse with no new error -> both 0 on the next cycle.
